uart_tx_fsm: RTL and testbench
==============================

// Module: uart_tx_fsm
// PURPOSE
//  Frame sequencer for the UART transmitter. Accepts a byte-ready strobe and steps the TX datapath
//  through start, data, optional parity and stop bits: serializer load/shift, parity latch and the
//  2-bit select of the registered TX output mux. One bit period per clock (baud-rate clock domain).
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame; bit counter width = $clog2(DATA_WIDTH)
// PORTS
//  CLK_FSM         in   1           clock (baud tick); all state updates on rising edge
//  RST_FSM         in   1           synchronous reset, active-high
//  DATA_VALID_FSM  in   1           new byte available on serializer parallel input
//  PAR_EN_FSM      in   1           frame carries a parity bit; sampled only at acceptance
//  mux_sel_FSM     out  2           00 start(0), 01 serial data, 10 parity, 11 idle/stop(1)
//  ser_load_FSM    out  1           1-cycle pulse: serializer captures parallel byte
//  ser_en_FSM      out  1           serializer shifts one bit at end of this cycle
//  par_latch_FSM   out  1           1-cycle pulse: parity calculator captures the byte
//  busy_FSM        out  1           frame in progress; upstream must hold DATA_VALID_FSM low
// BEHAVIOUR
//  States: IDLE, START, DATA, PARITY, STOP; state register + counter reset synchronously.
//  Reset (RST_FSM=1 at edge, any state, mid-frame included): next cycle state=IDLE, bit_cnt=0,
//   par_en_q=0, mux_sel=11, ser_load=0, ser_en=0, par_latch=0, busy=0.
//  Acceptance: in IDLE or STOP with DATA_VALID_FSM=1 -> ser_load=1 and par_latch=1 that same cycle
//   (Mealy pulse); PAR_EN_FSM latched into par_en_q; next state START. DATA_VALID_FSM is ignored
//   in START/DATA/PARITY.
//  IDLE:   mux_sel=11, busy=0. Stays until acceptance.
//  START:  mux_sel=00, busy=1, 1 cycle -> DATA with bit_cnt=0.
//  DATA:   mux_sel=01, ser_en=1, busy=1; bit_cnt increments each cycle; at bit_cnt=DATA_WIDTH-1
//          -> PARITY if par_en_q else STOP; bit_cnt returns to 0 (no wrap beyond DATA_WIDTH-1).
//  PARITY: mux_sel=10, busy=1, 1 cycle -> STOP.
//  STOP:   mux_sel=11, busy=1, 1 cycle; acceptance -> START (back-to-back, no idle gap), else IDLE.
//  Frame length: 1 + DATA_WIDTH + par_en_q + 1 cycles. mux_sel/busy are Moore outputs from the
//   state register (glitch-free); the TX output mux adds 1 cycle of register latency downstream.
//  PAR_EN_FSM change mid-frame has no effect until next acceptance.
//  Simultaneous RST_FSM and DATA_VALID_FSM: reset wins, no load/latch pulse takes effect.
//  Illegal state encodings recover to IDLE on the next clock.
// STRUCTURE
//  Shared package uart_tx_pkg: state encodings (3-bit localparams) and mux select constants
//   MUX_START=2'b00, MUX_DATA=2'b01, MUX_PAR=2'b10, MUX_IDLE=2'b11, reused by the output mux.
//  One sub-module: uart_tx_bit_counter (clear/enable, terminal-count flag at DATA_WIDTH-1).
//  Next-state logic and output decode in a single combinational block; state/counter/par_en_q
//   registered.
// TESTING
//  1 Reset: RST_FSM=1 2 cycles -> mux_sel=11, busy=0, all pulses 0; held while DATA_VALID_FSM=1.
//  2 PAR_EN=0, DATA_VALID 1 cycle -> load+latch pulse, mux_sel 00 x1, 01 x8, 11 x1, IDLE; busy 10 cycles.
//  3 PAR_EN=1 -> sequence 00, 01x8, 10, 11 (11 cycles busy); ser_en high exactly 8 cycles.
//  4 DATA_VALID high in STOP -> next cycle 00 (START) with no 11 idle gap; second frame completes.
//  5 PAR_EN toggled and DATA_VALID pulsed mid-DATA -> frame unchanged, no extra load pulse.
//  6 RST_FSM asserted at bit_cnt=4 -> next cycle IDLE, mux_sel=11, busy=0; fresh frame then correct.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings and TX output mux selects.
// The output mux imports the MUX_* constants so both ends agree on the select meaning.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_PAR   = 2'b10;
  localparam logic [1:0] MUX_IDLE  = 2'b11;

  // Counter width never drops to zero, even for a 1-bit frame.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_bit_counter.sv
// Data-bit counter for the UART TX frame sequencer.
// Clear has priority over enable; the count returns to 0 after its terminal value.
module uart_tx_bit_counter
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = cnt_width(DATA_WIDTH)
) (
  input  logic             CLK_CNT,
  input  logic             RST_CNT,
  input  logic             clr_CNT,
  input  logic             en_CNT,
  output logic [CNT_W-1:0] count_CNT,
  output logic             tc_CNT
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign tc_CNT    = (count_reg == LAST);
  assign count_CNT = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr_CNT) begin
      count_next = '0;
    end else if (en_CNT) begin
      count_next = tc_CNT ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK_CNT) begin
    if (RST_CNT) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits, optional parity, stop; one bit per clock.
// mux_sel/busy decode the state register only; load/latch pulses are Mealy on acceptance.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK_FSM,
  input  logic       RST_FSM,
  input  logic       DATA_VALID_FSM,
  input  logic       PAR_EN_FSM,
  output logic [1:0] mux_sel_FSM,
  output logic       ser_load_FSM,
  output logic       ser_en_FSM,
  output logic       par_latch_FSM,
  output logic       busy_FSM
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic             par_en_reg;
  logic             par_en_next;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;

  uart_tx_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .CLK_CNT   (CLK_FSM),
    .RST_CNT   (RST_FSM),
    .clr_CNT   (cnt_clr),
    .en_CNT    (cnt_en),
    .count_CNT (bit_cnt),
    .tc_CNT    (cnt_tc)
  );

  always_comb begin
    state_next  = state_reg;
    par_en_next = par_en_reg;
    mux_sel_FSM = MUX_IDLE;
    ser_en_FSM  = 1'b0;
    busy_FSM    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept = DATA_VALID_FSM;
      end
      ST_START: begin
        mux_sel_FSM = MUX_START;
        busy_FSM    = 1'b1;
        cnt_clr     = 1'b1;
        state_next  = ST_DATA;
      end
      ST_DATA: begin
        mux_sel_FSM = MUX_DATA;
        ser_en_FSM  = 1'b1;
        busy_FSM    = 1'b1;
        cnt_en      = 1'b1;
        if (cnt_tc) begin
          state_next = par_en_reg ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        mux_sel_FSM = MUX_PAR;
        busy_FSM    = 1'b1;
        state_next  = ST_STOP;
      end
      ST_STOP: begin
        busy_FSM   = 1'b1;
        accept     = DATA_VALID_FSM;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (accept) begin
      par_en_next = PAR_EN_FSM;
      state_next  = ST_START;
    end
  end

  // Reset beats a coincident byte strobe: no pulse may reach the serializer.
  assign ser_load_FSM  = accept & ~RST_FSM;
  assign par_latch_FSM = accept & ~RST_FSM;

  always_ff @(posedge CLK_FSM) begin
    if (RST_FSM) begin
      state_reg  <= ST_IDLE;
      par_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      par_en_reg <= par_en_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: per-cycle vectors queued as a scoreboard, one line per check.
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  localparam int DW = 8;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       par_en;
  logic [1:0] mux_sel;
  logic       ser_load;
  logic       ser_en;
  logic       par_latch;
  logic       busy;

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK_FSM        (clk),
    .RST_FSM        (rst),
    .DATA_VALID_FSM (valid),
    .PAR_EN_FSM     (par_en),
    .mux_sel_FSM    (mux_sel),
    .ser_load_FSM   (ser_load),
    .ser_en_FSM     (ser_en),
    .par_latch_FSM  (par_latch),
    .busy_FSM       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       par;
    logic [1:0] mux;
    logic       load;
    logic       en;
    logic       latch;
    logic       busy;
    string      name;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic p, input logic [1:0] m,
                              input logic ld, input logic e, input logic lt, input logic b,
                              input string n);
    vec_t x;
    x.rst = r; x.valid = v; x.par = p; x.mux = m;
    x.load = ld; x.en = e; x.latch = lt; x.busy = b; x.name = n;
    return x;
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled mid-cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [5:0] got;
    logic [5:0] want;
    @(posedge clk);
    #1;
    rst = v.rst; valid = v.valid; par_en = v.par;
    exp_q.push_back(v);
    #3;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e    = exp_q.pop_front();
      got  = {mux_sel, ser_load, ser_en, par_latch, busy};
      want = {e.mux, e.load, e.en, e.latch, e.busy};
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got mux=%b load=%b en=%b latch=%b busy=%b, want mux=%b load=%b en=%b latch=%b busy=%b",
                 e.name, got[5:4], got[3], got[2], got[1], got[0],
                 want[5:4], want[3], want[2], want[1], want[0]);
      end else begin
        $display("ok   %s: mux=%b load=%b en=%b latch=%b busy=%b",
                 e.name, got[5:4], got[3], got[2], got[1], got[0]);
      end
    end
  endtask

  // One frame from START through STOP, optionally preceded by an IDLE acceptance.
  // noise: strobe DATA_VALID and toggle PAR_EN during START/DATA, which must be ignored.
  task automatic frame(input logic p, input logic idle_accept, input logic noise,
                       input logic stop_accept, input logic next_p, input string tag);
    if (idle_accept)
      apply(mk(0, 1, p, MUX_IDLE, 1, 0, 1, 0, {tag, " accept"}));
    apply(mk(0, noise, noise ? ~p : p, MUX_START, 0, 0, 0, 1, {tag, " start"}));
    for (int i = 0; i < DW; i++) begin
      logic nv;
      logic np;
      nv = noise && (i == 3 || i == 5);
      np = noise ? logic'(i % 2) : p;
      apply(mk(0, nv, np, MUX_DATA, 0, 1, 0, 1, $sformatf("%s data%0d", tag, i)));
    end
    if (p)
      apply(mk(0, 0, p, MUX_PAR, 0, 0, 0, 1, {tag, " parity"}));
    apply(mk(0, stop_accept, next_p, MUX_IDLE, stop_accept, 0, stop_accept, 1, {tag, " stop"}));
  endtask

  vec_t table_vecs[6];

  initial begin
    rst = 1'b1; valid = 1'b1; par_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset behaviour and idle hold, table-driven.
    table_vecs[0] = mk(1, 1, 0, MUX_IDLE, 0, 0, 0, 0, "reset valid hi 0");
    table_vecs[1] = mk(1, 1, 1, MUX_IDLE, 0, 0, 0, 0, "reset valid hi 1");
    table_vecs[2] = mk(0, 0, 1, MUX_IDLE, 0, 0, 0, 0, "idle 0");
    table_vecs[3] = mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "idle 1");
    table_vecs[4] = mk(1, 1, 1, MUX_IDLE, 0, 0, 0, 0, "reset again");
    table_vecs[5] = mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "idle 2");
    for (int i = 0; i < 6; i++) apply(table_vecs[i]);

    // Plain frame, then parity frame.
    frame(0, 1, 0, 0, 0, "f_nopar");
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "f_nopar after"));
    frame(1, 1, 0, 0, 0, "f_par");
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "f_par after"));

    // Back-to-back: acceptance in STOP goes straight to START.
    frame(0, 1, 0, 1, 1, "b2b_a");
    frame(1, 0, 0, 0, 0, "b2b_b");
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "b2b after"));

    // Mid-frame PAR_EN toggles and DATA_VALID strobes are ignored.
    frame(0, 1, 1, 0, 0, "noise");
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "noise after"));

    // Reset at bit_cnt=4 aborts the frame; valid held high during reset.
    apply(mk(0, 1, 1, MUX_IDLE, 1, 0, 1, 0, "abort accept"));
    apply(mk(0, 0, 1, MUX_START, 0, 0, 0, 1, "abort start"));
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 1, MUX_DATA, 0, 1, 0, 1, $sformatf("abort data%0d", i)));
    apply(mk(1, 1, 1, MUX_DATA, 0, 1, 0, 1, "abort rst at cnt4"));
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "abort idle"));
    frame(1, 1, 0, 0, 0, "fresh");
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "fresh after"));

    // Reset in STOP with a coincident strobe: no pulse, then IDLE.
    frame(0, 1, 0, 0, 0, "pre_stoprst");
    apply(mk(0, 1, 0, MUX_IDLE, 1, 0, 1, 0, "stoprst accept"));
    apply(mk(0, 0, 0, MUX_START, 0, 0, 0, 1, "stoprst start"));
    for (int i = 0; i < DW; i++)
      apply(mk(0, 0, 0, MUX_DATA, 0, 1, 0, 1, $sformatf("stoprst data%0d", i)));
    apply(mk(1, 1, 0, MUX_IDLE, 0, 0, 0, 1, "stoprst rst+valid"));
    apply(mk(0, 0, 0, MUX_IDLE, 0, 0, 0, 0, "stoprst idle"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
